// File: rtl/shifter_pkg.sv
// Shared definitions for the sequential shifter: op codes and FSM states.
package shifter_pkg;

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b10;
   localparam logic [1:0] OP_SRA = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_e;

endpackage

// File: rtl/shift_step_1.sv
// Combinational one-bit shift selected by op.
// SEQ_SHIFTER_SRA_EN: when defined, OP_SRA fills the MSB with the sign bit;
// otherwise every non-SLL op (including reserved 01) is a logical right shift.
module shift_step_1
   import shifter_pkg::*;
#(
   parameter int unsigned Bits = 32
) (
   input  logic [Bits-1:0] data_i,
   input  logic [1:0]      op_i,
   output logic [Bits-1:0] data_o
);

   logic fill;

   // Pick the bit shifted into the vacated position, then shift by one.
   always_comb begin
      fill = 1'b0;
`ifdef SEQ_SHIFTER_SRA_EN
      if (op_i == OP_SRA) begin
         fill = data_i[Bits-1];
      end
`endif
      if (op_i == OP_SLL) begin
         data_o = {data_i[Bits-2:0], 1'b0};
      end else begin
         data_o = {fill, data_i[Bits-1:1]};
      end
   end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle variable-amount shifter, one bit per cycle, valid/ready on both sides.
// SEQ_SHIFTER_SRA_EN: enables sign-fill for op 11 (see shift_step_1).
module seq_shifter
   import shifter_pkg::*;
#(
   parameter int unsigned Bits = 32,
   parameter int unsigned SHW  = $clog2(Bits)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [Bits-1:0] in_data,
   input  logic [SHW-1:0]  in_shamt,
   input  logic [1:0]      in_op,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [Bits-1:0] out_data
);

   state_e          state_q, state_d;
   logic [Bits-1:0] result_q, result_d;
   logic [1:0]      op_q, op_d;
   logic [SHW-1:0]  count_q, count_d;
   logic [Bits-1:0] step_out;

   shift_step_1 #(.Bits(Bits)) u_step (
      .data_i (result_q),
      .op_i   (op_q),
      .data_o (step_out)
   );

   // Next-state, datapath update and handshake decode.
   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      op_d      = op_q;
      count_d   = count_q;
      in_ready  = (state_q == IDLE) && !rst;
      out_valid = (state_q == DONE);
      out_data  = result_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               result_d = in_data;
               op_d     = in_op;
               count_d  = in_shamt;
               state_d  = (in_shamt == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            result_d = step_out;
            count_d  = count_q - SHW'(1);
            if (count_q == SHW'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         result_q <= '0;
         op_q     <= OP_SLL;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         op_q     <= op_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: tb/tb_seq_shifter.sv
// Directed table-driven bench for seq_shifter plus backpressure and reset corner cases.
module tb_seq_shifter;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [4:0]  in_shamt;
   logic [1:0]  in_op;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;

   int unsigned total = 0;
   int unsigned bad   = 0;

   always #5 clk = ~clk;

   seq_shifter #(.Bits(32), .SHW(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_shamt  (in_shamt),
      .in_op     (in_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   typedef struct {
      logic [31:0] data;
      logic [4:0]  shamt;
      logic [1:0]  op;
      logic [31:0] exp;
   } vec_t;

`ifdef SEQ_SHIFTER_SRA_EN
   localparam logic [31:0] SRA_NEG4  = 32'hF8000000;
   localparam logic [31:0] SRA_NEG31 = 32'hFFFFFFFF;
`else
   localparam logic [31:0] SRA_NEG4  = 32'h08000000;
   localparam logic [31:0] SRA_NEG31 = 32'h00000001;
`endif

   vec_t vecs [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Present one request at a negedge, count edges after the accept edge until
   // out_valid, then check result and complete the output handshake.
   task automatic run_req(input string name, input logic [31:0] data, input logic [4:0] shamt,
                          input logic [1:0] op, input logic [31:0] exp);
      int unsigned lat;
      @(negedge clk);
      check({name, " in_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = data;
      in_shamt = shamt;
      in_op    = op;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = $urandom;
      in_shamt = 5'($urandom);
      in_op    = 2'($urandom);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      // shamt 0 finishes on the accept edge itself; otherwise one edge per bit.
      check({name, " latency"}, lat, 32'(shamt));
      check({name, " data"}, out_data, exp);
      check({name, " ready_in_done"}, 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check({name, " valid_after_hs"}, 32'(out_valid), 32'd0);
      check({name, " ready_after_hs"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      vecs[0]  = '{32'h0000ABCD, 5'd16, 2'b00, 32'hABCD0000};
      vecs[1]  = '{32'h80000000, 5'd31, 2'b10, 32'h00000001};
      vecs[2]  = '{32'h80000000, 5'd4,  2'b11, SRA_NEG4};
      vecs[3]  = '{32'h12345678, 5'd0,  2'b00, 32'h12345678};
      vecs[4]  = '{32'hF0000001, 5'd1,  2'b00, 32'hE0000002};
      vecs[5]  = '{32'h80000010, 5'd4,  2'b01, 32'h08000001};
      vecs[6]  = '{32'hFFFFFFFF, 5'd31, 2'b00, 32'h80000000};
      vecs[7]  = '{32'h7FFFFFFF, 5'd31, 2'b11, 32'h00000000};
      vecs[8]  = '{32'h80000000, 5'd31, 2'b11, SRA_NEG31};
      vecs[9]  = '{32'h12345678, 5'd8,  2'b10, 32'h00123456};
      vecs[10] = '{32'hC3C3C3C3, 5'd0,  2'b11, 32'hC3C3C3C3};
      vecs[11] = '{32'h00000001, 5'd1,  2'b10, 32'h00000000};

      rst       = 1'b1;
      in_valid  = 1'b1;
      in_data   = 32'hDEADBEEF;
      in_shamt  = 5'd0;
      in_op     = 2'b00;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst in_ready", 32'(in_ready), 32'd0);
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst out_data", out_data, 32'd0);
      check("rst count", 32'(dut.count_q), 32'd0);
      in_valid = 1'b0;
      rst      = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("post_rst in_ready", 32'(in_ready), 32'd1);
      check("post_rst out_valid", 32'(out_valid), 32'd0);

      for (int i = 0; i < 12; i++) begin
         run_req($sformatf("vec%0d", i), vecs[i].data, vecs[i].shamt, vecs[i].op, vecs[i].exp);
      end

      // Backpressure: DONE held with out_ready low; a new request must be ignored.
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 32'hA5A5A5A5;
      in_shamt = 5'd3;
      in_op    = 2'b10;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("bp valid", 32'(out_valid), 32'd1);
      for (int c = 0; c < 5; c++) begin
         in_valid = (c == 2);
         in_data  = 32'hDEADBEEF;
         in_shamt = 5'd0;
         in_op    = 2'b00;
         check($sformatf("bp data c%0d", c), out_data, 32'h14B4B4B4);
         check($sformatf("bp valid c%0d", c), 32'(out_valid), 32'd1);
         check($sformatf("bp ready c%0d", c), 32'(in_ready), 32'd0);
         @(posedge clk);
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check("bp idle valid", 32'(out_valid), 32'd0);
      check("bp idle ready", 32'(in_ready), 32'd1);
      check("bp idle data", out_data, 32'h14B4B4B4);
      run_req("bp next", 32'h00000003, 5'd2, 2'b00, 32'h0000000C);

      // Reset mid-shift: shamt 20, rst once count has reached 8.
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 32'h00000001;
      in_shamt = 5'd20;
      in_op    = 2'b00;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (12) @(posedge clk);
      @(negedge clk);
      check("mid count", 32'(dut.count_q), 32'd8);
      check("mid valid", 32'(out_valid), 32'd0);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("mid_rst valid", 32'(out_valid), 32'd0);
      check("mid_rst data", out_data, 32'd0);
      check("mid_rst ready", 32'(in_ready), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("after_rst ready", 32'(in_ready), 32'd1);
      check("after_rst valid", 32'(out_valid), 32'd0);
      run_req("after_rst req", 32'h0000ABCD, 5'd16, 2'b00, 32'hABCD0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
